// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types, default sizes and address helper for the
//               memory-side controller and its response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int MEM_PA_WIDTH   = 32;
  localparam int MEM_LINE_WIDTH = 128;
  localparam int MEM_ID_WIDTH   = 4;
  localparam int MEM_NUM_LINES  = 256;
  localparam int MEM_LATENCY    = 4;
  localparam int MEM_RESP_DEPTH = 4;

  // Byte offset inside a line, and number of line-index bits above it
  localparam int MEM_LINE_OFF = $clog2(MEM_LINE_WIDTH / 8);
  localparam int MEM_IDX_W    = $clog2(MEM_NUM_LINES);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic [MEM_ID_WIDTH-1:0]   id;
    logic [MEM_LINE_WIDTH-1:0] line;
  } mem_resp_t;

  // Line index of a byte address; upper bits are dropped so addresses wrap
  function automatic logic [MEM_IDX_W-1:0] line_index(input logic [MEM_PA_WIDTH-1:0] addr);
    return addr[MEM_LINE_OFF +: MEM_IDX_W];
  endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : resp_fifo
// Description : Synchronous FIFO of {id, line} responses. Pop on an empty
//               FIFO is ignored; a push is taken when a slot is free or is
//               freed by a pop on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module resp_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = MEM_RESP_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  mem_resp_t                  push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output mem_resp_t                  head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  mem_resp_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Qualify handshakes and advance pointers/occupancy
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset; occupancy decides what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule : resp_fifo
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Memory-side controller. Accepts one request at a time from
//               the arbiter queue, models a fixed-latency line store and
//               returns in-order {id, line} responses through a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int PA_WIDTH   = MEM_PA_WIDTH,
  parameter int LINE_WIDTH = MEM_LINE_WIDTH,
  parameter int ID_WIDTH   = MEM_ID_WIDTH,
  parameter int MEM_LINES  = MEM_NUM_LINES,
  parameter int LATENCY    = MEM_LATENCY,
  parameter int RESP_DEPTH = MEM_RESP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic [ID_WIDTH-1:0]   i_id,
  input  logic [PA_WIDTH-1:0]   i_addr,
  input  logic [LINE_WIDTH-1:0] i_data,
  input  logic                  i_write,
  output logic                  o_ack,
  output logic                  o_resp_enable,
  output logic [ID_WIDTH-1:0]   o_resp_id,
  output logic [LINE_WIDTH-1:0] o_resp_data,
  input  logic                  i_resp_ack,
  output logic                  o_idle
);

  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int FCNT_W = $clog2(RESP_DEPTH) + 1;

  mem_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ack_q, ack_d;
  logic [ID_WIDTH-1:0]   req_id_q, req_id_d;
  logic [IDX_W-1:0]      req_idx_q, req_idx_d;
  logic [LINE_WIDTH-1:0] req_data_q, req_data_d;
  logic                  req_write_q, req_write_d;
  logic                  store_we;

  logic [LINE_WIDTH-1:0] store_q [MEM_LINES];

  logic                  fifo_push;
  mem_resp_t             fifo_push_data;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FCNT_W-1:0]     fifo_count;
  mem_resp_t             fifo_head;

  // Request FSM: accept in IDLE when a response slot is free, count down in WAIT
  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    ack_d               = 1'b0;
    req_id_d            = req_id_q;
    req_idx_d           = req_idx_q;
    req_data_d          = req_data_q;
    req_write_d         = req_write_q;
    store_we            = 1'b0;
    fifo_push           = 1'b0;
    fifo_push_data.id   = req_id_q;
    fifo_push_data.line = req_write_q ? req_data_q : store_q[req_idx_q];
    case (state_q)
      IDLE: begin
        // A free slot now stays free until the push: only pops happen meanwhile
        if (i_enable && !fifo_full) begin
          req_id_d    = i_id;
          req_idx_d   = line_index(i_addr);
          req_data_d  = i_data;
          req_write_d = i_write;
          cnt_d       = CNT_W'(LATENCY - 1);
          ack_d       = 1'b1;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          fifo_push = 1'b1;
          store_we  = req_write_q;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and request-latch registers; reset drops any in-flight request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      req_id_q    <= '0;
      req_idx_q   <= '0;
      req_data_q  <= '0;
      req_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      req_id_q    <= req_id_d;
      req_idx_q   <= req_idx_d;
      req_data_q  <= req_data_d;
      req_write_q <= req_write_d;
    end
  end

  // Backing store keeps its contents across reset
  always_ff @(posedge clk) begin
    if (store_we) store_q[req_idx_q] <= req_data_q;
  end

  assign fifo_pop = i_resp_ack && !fifo_empty;

  resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign o_ack         = ack_q;
  assign o_resp_enable = !fifo_empty;
  assign o_resp_id     = fifo_head.id;
  assign o_resp_data   = fifo_head.line;
  assign o_idle        = (state_q == IDLE) && (fifo_count == '0);

endmodule : mem_ctrl
`default_nettype wire
